// File: rtl/clarke_pkg.sv
// clarke_pkg -- constants and helpers shared by the forward and inverse
// Clarke transforms.
//   inv_sqrt3(w) : round(0.577350269 * (2**(w-1)-1)), the 1/sqrt(3) gain in
//                  the Q(w-1) scaling used by the w-bit datapath.
//   sat_sym(v,w) : clamps v to the symmetric range +/-(2**(w-1)-1) and flags
//                  whether clamping happened.
package clarke_pkg;

  typedef struct packed {
    logic               sat;
    logic signed [63:0] val;
  } sat_res_t;

  // Integer-only rounding so the constant can be evaluated at elaboration
  // without real arithmetic.
  function automatic longint inv_sqrt3(input int unsigned w);
    longint full_scale;
    full_scale = (longint'(1) << (w - 1)) - longint'(1);
    return (longint'(577350269) * full_scale + longint'(500000000))
           / longint'(1000000000);
  endfunction

  // Symmetric limit keeps the most negative code unused, so negating a
  // clamped result can never overflow.
  function automatic sat_res_t sat_sym(input logic signed [63:0] v,
                                       input int unsigned w);
    sat_res_t           res;
    logic signed [63:0] lim;
    lim = (64'sd1 <<< (w - 1)) - 64'sd1;
    res.sat = 1'b0;
    res.val = v;
    if (v > lim) begin
      res.sat = 1'b1;
      res.val = lim;
    end else if (v < -lim) begin
      res.sat = 1'b1;
      res.val = -lim;
    end
    return res;
  endfunction

endpackage

// File: rtl/clarke_pipe_stage.sv
// clarke_pipe_stage -- one valid/ready register slice.
// Ports:
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   in_valid_i/in_ready_o   : upstream handshake
//   in_data_i [W-1:0]       : payload from upstream
//   out_valid_o/out_ready_i : downstream handshake
//   out_data_o [W-1:0]      : registered payload
// Handshake: a word transfers on a rising edge where valid and ready are
// both high; valid never waits on ready, and a presented word with its
// valid stays unchanged until it is taken.
// The slice loads when it is empty or when its word leaves in the same
// cycle, so in_ready_o is combinational from out_ready_i and bubbles
// collapse through a chain of these slices.
module clarke_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready_o) begin
      valid_d = in_valid_i;
      if (in_valid_i) begin
        data_d = in_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/clarke_fwd_module.sv
// clarke_fwd_module -- forward Clarke transform, 3-stage valid/ready pipeline.
//   al = a
//   be = ((a + 2b) * INV_SQRT3) >>> (DATA_WIDTH-1)   (floor shift)
// Ports:
//   clk_i, rst_i           : clock, asynchronous active-high reset
//   a_i, b_i               : signed phase samples, valid_i/ready_o handshake
//   al_o, be_o, sat_o      : signed results and clamp flag, valid_o/ready_i
// Stages: S1 holds {a, a+2b}, S2 holds {a, product}, S3 holds the outputs.
// Build option: define CLARKE_FWD_SAT_EN to clamp be_o to the symmetric
// range and report it on sat_o; otherwise be_o wraps and sat_o is 0.
module clarke_fwd_module
  import clarke_pkg::*;
#(
  parameter int DATA_WIDTH = 10
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic signed [DATA_WIDTH-1:0] a_i,
  input  logic signed [DATA_WIDTH-1:0] b_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  output logic signed [DATA_WIDTH-1:0] al_o,
  output logic signed [DATA_WIDTH-1:0] be_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic                         sat_o
);

  localparam int DW  = DATA_WIDTH;
  localparam int SW  = DW + 2;       // a + 2b never overflows this
  localparam int PW  = 2 * DW + 2;   // sum * gain never overflows this
  localparam int S1W = DW + SW;
  localparam int S2W = DW + PW;
  localparam int S3W = 2 * DW + 1;
  localparam logic signed [PW-1:0] K_INV_SQRT3 = PW'(inv_sqrt3(DW));

  // S1 input: a and a+2b
  logic signed [SW-1:0] sum_in;
  logic [S1W-1:0]       s1_in, s1_out;
  logic                 s1_valid, s2_ready;

  assign sum_in = SW'(a_i) + (SW'(b_i) <<< 1);
  assign s1_in  = {a_i, sum_in};

  clarke_pipe_stage #(.W(S1W)) u_s1 (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (valid_i),
    .in_ready_o  (ready_o),
    .in_data_i   (s1_in),
    .out_valid_o (s1_valid),
    .out_ready_i (s2_ready),
    .out_data_o  (s1_out)
  );

  // S2 input: a and the full-precision product
  logic signed [SW-1:0] s1_sum;
  logic signed [PW-1:0] prod_in;
  logic [S2W-1:0]       s2_in, s2_out;
  logic                 s2_valid, s3_ready;

  assign s1_sum  = $signed(s1_out[SW-1:0]);
  assign prod_in = PW'(s1_sum) * K_INV_SQRT3;
  assign s2_in   = {s1_out[S1W-1:SW], prod_in};

  clarke_pipe_stage #(.W(S2W)) u_s2 (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (s1_valid),
    .in_ready_o  (s2_ready),
    .in_data_i   (s2_in),
    .out_valid_o (s2_valid),
    .out_ready_i (s3_ready),
    .out_data_o  (s2_out)
  );

  // S3 input: shifted product, limited to the output width
  logic signed [PW-1:0] s2_prod;
  logic signed [PW-1:0] shifted;
  logic [DW-1:0]        be_in;
  logic                 sat_in;
  logic [S3W-1:0]       s3_in, s3_out;

  assign s2_prod = $signed(s2_out[PW-1:0]);
  assign shifted = s2_prod >>> (DW - 1);

`ifdef CLARKE_FWD_SAT_EN
  sat_res_t sat_res;
  logic     unused_sat_hi;
  assign sat_res       = sat_sym(64'(shifted), DW);
  assign be_in         = sat_res.val[DW-1:0];
  assign sat_in        = sat_res.sat;
  assign unused_sat_hi = ^sat_res.val[63:DW];
`else
  // Wrap-around: keep only the low bits of the shifted value.
  logic unused_shift_hi;
  assign be_in           = shifted[DW-1:0];
  assign sat_in          = 1'b0;
  assign unused_shift_hi = ^shifted[PW-1:DW];
`endif

  assign s3_in = {s2_out[S2W-1:PW], be_in, sat_in};

  clarke_pipe_stage #(.W(S3W)) u_s3 (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (s2_valid),
    .in_ready_o  (s3_ready),
    .in_data_i   (s3_in),
    .out_valid_o (valid_o),
    .out_ready_i (ready_i),
    .out_data_o  (s3_out)
  );

  assign al_o  = $signed(s3_out[S3W-1:DW+1]);
  assign be_o  = $signed(s3_out[DW:1]);
  assign sat_o = s3_out[0];

endmodule

// File: tb/tb_clarke_fwd_module.sv
module tb_clarke_fwd_module;

  localparam int DW = 10;
  localparam int EW = 2 * DW + 1;   // {al, be, sat}

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_i;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic signed [DW-1:0] a_i, b_i, al_o, be_o;
  logic valid_i, ready_o, valid_o, ready_i, sat_o;

  clarke_fwd_module #(.DATA_WIDTH(DW)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .al_o    (al_o),
    .be_o    (be_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .sat_o   (sat_o)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: floor((a+2b)*295 / 512), then limit or wrap to 10 bits.
  function automatic logic [EW-1:0] model(input int a, input int b);
    longint p;
    longint sh;
    logic [DW-1:0] be;
    logic sat;
    p  = longint'(a + 2 * b) * longint'(295);
    sh = p >>> 9;
    sat = 1'b0;
`ifdef CLARKE_FWD_SAT_EN
    if (sh > 511) begin
      sh = 511; sat = 1'b1;
    end else if (sh < -511) begin
      sh = -511; sat = 1'b1;
    end
`endif
    be = sh[DW-1:0];
    return {10'(a), be, sat};
  endfunction

  // ---------------- driver tasks ----------------
  // One sample into an idle pipe with ready_i high; result must appear
  // exactly 3 cycles after acceptance.
  task automatic run_single(input string tag, input int a, input int b,
                            input int exp_al, input int exp_be,
                            input logic exp_sat);
    @(negedge clk);
    a_i = 10'(a); b_i = 10'(b); valid_i = 1'b1; ready_i = 1'b1;
    #1 check({tag, "_ready_o"}, ready_o, 1);
    @(negedge clk);
    valid_i = 1'b0;
    check({tag, "_valid_c1"}, valid_o, 0);
    @(negedge clk);
    check({tag, "_valid_c2"}, valid_o, 0);
    @(negedge clk);
    check({tag, "_valid_c3"}, valid_o, 1);
    check({tag, "_al"}, al_o, exp_al);
    check({tag, "_be"}, be_o, exp_be);
    check({tag, "_sat"}, sat_o, exp_sat);
  endtask

  // ---------------- stimulus ----------------
  int sa[8];
  int sb[8];
  int sent, rcvd, cyc;
  logic stalled;
  logic signed [DW-1:0] hold_al, hold_be;
  logic hold_sat;
  logic [EW-1:0] e;

  initial begin
    sa = '{100, 200, -300, 511, -512, 0, 37, -1};
    sb = '{0, 100, 50, 511, -512, -256, -19, 255};
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0; a_i = '0; b_i = '0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_valid_o", valid_o, 0);
    check("rst_al_o", al_o, 0);
    check("rst_be_o", be_o, 0);
    check("rst_sat_o", sat_o, 0);
    rst_i = 1'b0;
    #1 check("post_rst_ready_o", ready_o, 1);

    // directed vectors
    run_single("v100_0", 100, 0, 100, 57, 1'b0);
    run_single("v200_100", 200, 100, 200, 230, 1'b0);
`ifdef CLARKE_FWD_SAT_EN
    run_single("vmax", 511, 511, 511, 511, 1'b1);
    run_single("vmin", -512, -512, -512, -511, 1'b1);
`else
    run_single("vmax", 511, 511, 511, -141, 1'b0);
    run_single("vmin", -512, -512, -512, 139, 1'b0);
`endif

    // stream with ready_i pattern 1,0,0,...
    sent = 0; rcvd = 0; cyc = 0; stalled = 1'b0;
    hold_al = '0; hold_be = '0; hold_sat = 1'b0;
    while (rcvd < 8 && cyc < 300) begin
      @(negedge clk);
      if (stalled) begin
        check("stall_valid", valid_o, 1);
        check("stall_al", al_o, hold_al);
        check("stall_be", be_o, hold_be);
        check("stall_sat", sat_o, hold_sat);
      end
      ready_i = (cyc % 3 == 0);
      if (sent < 8) begin
        valid_i = 1'b1; a_i = 10'(sa[sent]); b_i = 10'(sb[sent]);
      end else begin
        valid_i = 1'b0;
      end
      #1;
      check("stream_ready_o", ready_o, !(exp_q.size() == 3 && !ready_i));
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          check("stream_spurious", valid_o, 0);
        end else begin
          e = exp_q.pop_front();
          check("stream_al", al_o, $signed(e[EW-1:DW+1]));
          check("stream_be", be_o, $signed(e[DW:1]));
          check("stream_sat", sat_o, e[0]);
          rcvd++;
        end
      end
      if (valid_i && ready_o) begin
        exp_q.push_back(model(sa[sent], sb[sent]));
        sent++;
      end
      stalled = valid_o && !ready_i;
      hold_al = al_o; hold_be = be_o; hold_sat = sat_o;
      cyc++;
    end
    check("stream_rcvd", rcvd, 8);
    check("stream_q_empty", exp_q.size(), 0);
    @(negedge clk);
    valid_i = 1'b0; ready_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stream_no_extra", valid_o, 0);
    end

    // reset with 3 samples in flight
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      valid_i = 1'b1; a_i = 10'(i + 1); b_i = 10'(i + 1);
      #1 check("fill_ready_o", ready_o, 1);
    end
    @(negedge clk);
    valid_i = 1'b0;
    #1 check("full_ready_o", ready_o, 0);
    check("full_valid_o", valid_o, 1);
    #2 rst_i = 1'b1;
    #1 check("async_rst_valid_o", valid_o, 0);
    check("async_rst_al_o", al_o, 0);
    check("async_rst_be_o", be_o, 0);
    @(negedge clk);
    rst_i = 1'b0; ready_i = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_no_stale", valid_o, 0);
    end
    run_single("post_rst_v100", 100, 0, 100, 57, 1'b0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
